// File: rtl/direct_ro_pkg.sv
// Shared types and default timing constants for the direct-readout sequencer.
package direct_ro_pkg;

    localparam int unsigned SETUP_CYC_DEF = 4;
    localparam int unsigned READ_CYC_DEF  = 2;
    localparam int unsigned GAP_CYC_DEF   = 2;
    localparam int unsigned HOLD_CYC_DEF  = 3;
    localparam int unsigned MAX_READS_DEF = 1024;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned CTR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        READ_HI,
        READ_LO,
        HOLD
    } ro_state_e;

    // Down-counter load value for a phase of 'cyc' cycles (counter expires at zero).
    function automatic logic [CNT_W-1:0] phase_load(input int unsigned cyc);
        return (cyc == 0) ? '0 : CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/ro_sync2.sv
// Two-flop synchronizer; BYPASS passes the input straight through.
module ro_sync2 #(
    parameter bit BYPASS = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = BYPASS ? i_d : r_sync[1];

endmodule

// File: rtl/direct_ro_sequencer.sv
// Freeze/read strobe sequencer for direct pixel-chip readout.
// Define DIRECT_RO_TOKEN_SYNC_EN to pass TOKEN through a 2-flop synchronizer.
module direct_ro_sequencer
    import direct_ro_pkg::*;
#(
    parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
    parameter int unsigned READ_CYC  = READ_CYC_DEF,
    parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
    parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
    parameter int unsigned MAX_READS = MAX_READS_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic             TOKEN,
    input  logic             FIFO_FULL,
    input  logic             CLR_ERR,
    output logic             FREEZE,
    output logic             READ,
    output logic             HIT_STROBE,
    output logic             BUSY,
    output logic [CTR_W-1:0] READ_COUNT,
    output logic [CTR_W-1:0] FRAME_COUNT,
    output logic             ABORT_ERR
);

`ifdef DIRECT_RO_TOKEN_SYNC_EN
    localparam bit TOK_BYPASS = 1'b0;
`else
    localparam bit TOK_BYPASS = 1'b1;
`endif

    localparam logic [CTR_W-1:0] MAX_RD = CTR_W'(MAX_READS);

    ro_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_freeze, w_freeze_nxt;
    logic             r_read, w_read_nxt;
    logic             r_hit, w_hit_nxt;
    logic             r_busy, w_busy_nxt;
    logic [CTR_W-1:0] r_read_count, w_read_count_nxt;
    logic [CTR_W-1:0] r_frame_count, w_frame_count_nxt;
    logic             r_abort_err, w_abort_nxt;
    logic             w_tok_s;
    logic             w_cnt_zero;

    ro_sync2 #(
        .BYPASS (TOK_BYPASS)
    ) u_tok_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (TOKEN),
        .o_q   (w_tok_s)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // Next-state and next-output logic; a single down-counter times every phase.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_freeze_nxt      = r_freeze;
        w_read_nxt        = 1'b0;
        w_hit_nxt         = 1'b0;
        w_read_count_nxt  = r_read_count;
        w_frame_count_nxt = r_frame_count;
        w_abort_nxt       = r_abort_err & ~CLR_ERR;

        case (r_state)
            IDLE: begin
                w_freeze_nxt = 1'b0;
                if (ENABLE && w_tok_s) begin
                    w_state_nxt      = SETUP;
                    w_cnt_nxt        = phase_load(SETUP_CYC);
                    w_freeze_nxt     = 1'b1;
                    w_read_count_nxt = '0;
                end
            end
            SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt      = READ_HI;
                    w_cnt_nxt        = phase_load(READ_CYC);
                    w_read_nxt       = 1'b1;
                    w_read_count_nxt = r_read_count + CTR_W'(1);
                end
            end
            READ_HI: begin
                // Pulse always runs to full width regardless of TOKEN/ENABLE.
                if (w_cnt_zero) begin
                    w_state_nxt = READ_LO;
                    w_cnt_nxt   = phase_load(GAP_CYC);
                    w_hit_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    w_read_nxt = 1'b1;
                end
            end
            READ_LO: begin
                if (w_cnt_zero) begin
                    if (!w_tok_s || !ENABLE || (r_read_count == MAX_RD)) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = phase_load(HOLD_CYC);
                        if (r_read_count == MAX_RD) begin
                            w_abort_nxt = 1'b1;
                        end
                    end else if (!FIFO_FULL) begin
                        w_state_nxt      = READ_HI;
                        w_cnt_nxt        = phase_load(READ_CYC);
                        w_read_nxt       = 1'b1;
                        w_read_count_nxt = r_read_count + CTR_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt       = IDLE;
                    w_freeze_nxt      = 1'b0;
                    w_frame_count_nxt = r_frame_count + CTR_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_freeze_nxt = 1'b0;
            end
        endcase

        if (r_state == SETUP && !w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_freeze      <= 1'b0;
            r_read        <= 1'b0;
            r_hit         <= 1'b0;
            r_busy        <= 1'b0;
            r_read_count  <= '0;
            r_frame_count <= '0;
            r_abort_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_freeze      <= w_freeze_nxt;
            r_read        <= w_read_nxt;
            r_hit         <= w_hit_nxt;
            r_busy        <= w_busy_nxt;
            r_read_count  <= w_read_count_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_abort_err   <= w_abort_nxt;
        end
    end

    assign FREEZE      = r_freeze;
    assign READ        = r_read;
    assign HIT_STROBE  = r_hit;
    assign BUSY        = r_busy;
    assign READ_COUNT  = r_read_count;
    assign FRAME_COUNT = r_frame_count;
    assign ABORT_ERR   = r_abort_err;

endmodule
